// File: rtl/cc_decoder_write.sv
// Write-side decoder for the register bank: captures one write request, strobes the
// one-hot load enable for the selected register, then acknowledges or rejects it.
module cc_decoder_write #(
    parameter int unsigned DATAWIDTH_BUS           = 32,
    parameter int unsigned DATAWIDTH_MUX_SELECTION = 6,
    parameter int unsigned NUM_REGS                = 38,
    parameter int unsigned PROTECT_REG0            = 1
) (
    input  logic                               CC_DECODER_WRITE_CLOCK_50,
    input  logic                               CC_DECODER_WRITE_RESET_InHigh,
    input  logic                               CC_DECODER_WRITE_Request_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0] CC_DECODER_WRITE_Selection_In,
    input  logic [DATAWIDTH_BUS-1:0]           CC_DECODER_WRITE_DataBUS_In,
    output logic [DATAWIDTH_BUS-1:0]           CC_DECODER_WRITE_DataBUS_Out,
    output logic [NUM_REGS-1:0]                CC_DECODER_WRITE_Load_Out,
    output logic                               CC_DECODER_WRITE_Busy_Out,
    output logic                               CC_DECODER_WRITE_Ack_Out,
    output logic                               CC_DECODER_WRITE_Error_Out
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                             state;
    state_t                             state_next;
    logic [DATAWIDTH_MUX_SELECTION-1:0] sel_r;
    logic                               sel_ok;

    // Target must exist and must not be the protected register 0.
    assign sel_ok = (32'(sel_r) < NUM_REGS) &&
                    !((PROTECT_REG0 != 0) && (sel_r == '0));

    always_ff @(posedge CC_DECODER_WRITE_CLOCK_50) begin
        if (CC_DECODER_WRITE_RESET_InHigh) begin
            state                        <= IDLE;
            sel_r                        <= '0;
            CC_DECODER_WRITE_DataBUS_Out <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && CC_DECODER_WRITE_Request_In) begin
                sel_r                        <= CC_DECODER_WRITE_Selection_In;
                CC_DECODER_WRITE_DataBUS_Out <= CC_DECODER_WRITE_DataBUS_In;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (CC_DECODER_WRITE_Request_In) state_next = LOAD;
            LOAD:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes depend only on registered state and sel_r, never on live inputs.
    always_comb begin
        CC_DECODER_WRITE_Load_Out  = '0;
        CC_DECODER_WRITE_Busy_Out  = (state != IDLE);
        CC_DECODER_WRITE_Ack_Out   = 1'b0;
        CC_DECODER_WRITE_Error_Out = 1'b0;
        case (state)
            LOAD: begin
                if (sel_ok) CC_DECODER_WRITE_Load_Out = NUM_REGS'(1) << sel_r;
            end
            DONE: begin
                CC_DECODER_WRITE_Ack_Out   = sel_ok;
                CC_DECODER_WRITE_Error_Out = !sel_ok;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cc_decoder_write.sv
// Scoreboard bench for cc_decoder_write: two instances (register 0 protected and not)
// share stimulus; a transaction-level model predicts load/ack/error events per cycle.
module tb_cc_decoder_write;

    localparam int NR = 38;

    typedef struct {
        int            cyc;
        logic [NR-1:0] load;
        logic          ack;
        logic          err;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          req;
    logic [5:0]    sel;
    logic [31:0]   din;

    logic [31:0]   dout  [2];
    logic [NR-1:0] load  [2];
    logic          busy  [2];
    logic          ack   [2];
    logic          err   [2];

    ev_t           sbq [2][$];
    int            ecount      = 0;
    int            free_edge   = 0;
    int            busy_end    = -1;
    logic [31:0]   exp_data    = '0;
    int            accepted    = 0;
    int            pulses_exp  [2] = '{0, 0};
    int            pulses_seen [2] = '{0, 0};
    int            checks      = 0;
    int            errors      = 0;

    cc_decoder_write #(.NUM_REGS(NR), .PROTECT_REG0(1)) dut_p (
        .CC_DECODER_WRITE_CLOCK_50    (clk),
        .CC_DECODER_WRITE_RESET_InHigh(rst),
        .CC_DECODER_WRITE_Request_In  (req),
        .CC_DECODER_WRITE_Selection_In(sel),
        .CC_DECODER_WRITE_DataBUS_In  (din),
        .CC_DECODER_WRITE_DataBUS_Out (dout[0]),
        .CC_DECODER_WRITE_Load_Out    (load[0]),
        .CC_DECODER_WRITE_Busy_Out    (busy[0]),
        .CC_DECODER_WRITE_Ack_Out     (ack[0]),
        .CC_DECODER_WRITE_Error_Out   (err[0])
    );

    cc_decoder_write #(.NUM_REGS(NR), .PROTECT_REG0(0)) dut_u (
        .CC_DECODER_WRITE_CLOCK_50    (clk),
        .CC_DECODER_WRITE_RESET_InHigh(rst),
        .CC_DECODER_WRITE_Request_In  (req),
        .CC_DECODER_WRITE_Selection_In(sel),
        .CC_DECODER_WRITE_DataBUS_In  (din),
        .CC_DECODER_WRITE_DataBUS_Out (dout[1]),
        .CC_DECODER_WRITE_Load_Out    (load[1]),
        .CC_DECODER_WRITE_Busy_Out    (busy[1]),
        .CC_DECODER_WRITE_Ack_Out     (ack[1]),
        .CC_DECODER_WRITE_Error_Out   (err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transaction model: a request is taken at an edge only if the previous write
    // (three cycles long) has finished; reset drops every event not yet presented.
    always @(posedge clk) begin
        ecount = ecount + 1;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                while (sbq[d].size() > 0 && sbq[d][$].cyc >= ecount) begin
                    if (sbq[d][$].ack || sbq[d][$].err) pulses_exp[d]--;
                    void'(sbq[d].pop_back());
                end
            end
            busy_end  = -1;
            free_edge = ecount + 1;
            exp_data  = '0;
        end else if (req && ecount >= free_edge) begin
            int sel_i;
            sel_i     = int'(sel);
            accepted  = accepted + 1;
            exp_data  = din;
            busy_end  = ecount + 1;
            free_edge = ecount + 3;
            for (int d = 0; d < 2; d++) begin
                ev_t e;
                logic ok;
                ok = (sel_i < NR) && !(d == 0 && sel_i == 0);
                if (ok) begin
                    e.cyc = ecount; e.load = '0; e.load[sel_i] = 1'b1;
                    e.ack = 1'b0; e.err = 1'b0;
                    sbq[d].push_back(e);
                end
                e.cyc = ecount + 1; e.load = '0; e.ack = ok; e.err = !ok;
                sbq[d].push_back(e);
                pulses_exp[d]++;
            end
        end
    end

    task automatic mon(input int d);
        ev_t e;
        while (sbq[d].size() > 0 && sbq[d][0].cyc < ecount) begin
            checks++; errors++;
            $display("FAIL missed_event dut%0d: nothing seen, required load=%h ack=%b err=%b in cycle %0d (now %0d)",
                     d, sbq[d][0].load, sbq[d][0].ack, sbq[d][0].err, sbq[d][0].cyc, ecount);
            void'(sbq[d].pop_front());
        end
        checks++;
        if (busy[d] !== (ecount <= busy_end)) begin
            errors++;
            $display("FAIL busy dut%0d cycle %0d: got %b required %b", d, ecount, busy[d], (ecount <= busy_end));
        end
        checks++;
        if (dout[d] !== exp_data) begin
            errors++;
            $display("FAIL data_out dut%0d cycle %0d: got %h required %h", d, ecount, dout[d], exp_data);
        end
        if (load[d] !== '0 || ack[d] !== 1'b0 || err[d] !== 1'b0) begin
            if (ack[d] === 1'b1 || err[d] === 1'b1) pulses_seen[d]++;
            checks++;
            if ($countones(load[d]) > 1 || (ack[d] === 1'b1 && err[d] === 1'b1)) begin
                errors++;
                $display("FAIL exclusive dut%0d cycle %0d: got load=%h ack=%b err=%b, required at most one strobe",
                         d, ecount, load[d], ack[d], err[d]);
            end
            checks++;
            if (sbq[d].size() == 0 || sbq[d][0].cyc != ecount) begin
                errors++;
                $display("FAIL unexpected_output dut%0d cycle %0d: got load=%h ack=%b err=%b, required no strobe",
                         d, ecount, load[d], ack[d], err[d]);
            end else begin
                e = sbq[d].pop_front();
                if (load[d] !== e.load || ack[d] !== e.ack || err[d] !== e.err) begin
                    errors++;
                    $display("FAIL event dut%0d cycle %0d: got load=%h ack=%b err=%b required load=%h ack=%b err=%b",
                             d, ecount, load[d], ack[d], err[d], e.load, e.ack, e.err);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic step(input logic r, input logic q, input logic [5:0] s, input logic [31:0] dt);
        @(posedge clk);
        #1;
        rst = r; req = q; sel = s; din = dt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'($urandom_range(0, 63)), $urandom);
    endtask

    initial begin
        int target;
        rst = 1'b1; req = 1'b1; sel = 6'd5; din = 32'h1234_5678;
        step(1'b1, 1'b1, 6'd5, 32'h1111_1111);
        step(1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 6'd7, 32'h0BAD_F00D);
        idle(3);
        // Boundary selections, one isolated write each
        step(1'b0, 1'b1, 6'd37, 32'hA5A5_0037); idle(3);
        step(1'b0, 1'b1, 6'd38, 32'hA5A5_0038); idle(3);
        step(1'b0, 1'b1, 6'd63, 32'hA5A5_003F); idle(3);
        step(1'b0, 1'b1, 6'd0,  32'hA5A5_0000); idle(3);
        // Request held high, selection and data changing every cycle
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 6'(i), $urandom);
        idle(3);
        // Reset lands on the edge that would enter DONE
        step(1'b0, 1'b1, 6'd9, 32'h9999_0001);
        step(1'b1, 1'b0, 6'd9, 32'h9999_0002);
        step(1'b0, 1'b0, 6'd9, 32'h9999_0003);
        idle(2);
        step(1'b0, 1'b1, 6'd9, 32'h9999_0004);
        idle(4);
        target = accepted + 200;
        for (int n = 0; n < 3000 && accepted < target; n++)
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                 6'($urandom_range(0, 63)), $urandom);
        idle(6);
        checks++;
        if (accepted < target) begin
            errors++;
            $display("FAIL random_count: got %0d accepted required %0d", accepted, target);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (sbq[d].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d: got %0d pending events required 0", d, sbq[d].size());
            end
            checks++;
            if (pulses_seen[d] != pulses_exp[d]) begin
                errors++;
                $display("FAIL pulse_total dut%0d: got %0d ack+error pulses required %0d", d, pulses_seen[d], pulses_exp[d]);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
